apb_uart_tx_arbiter: RTL and testbench

APB_UART_TX_ARBITER -- requirements
Module: apb_uart_tx_arbiter

---
 rtl/apb_uart_tx_arbiter_pkg.sv | 25 ++
 rtl/apb_uart_tx_arbiter_rr_arbiter.sv | 43 ++++
 rtl/apb_uart_tx_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_apb_uart_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_tx_arbiter_pkg.sv
// Shared SoC config for the UART TX arbiter: APB master state encodings and UART port map.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package apb_uart_tx_arbiter_pkg;

  // APB master phases. IDLE is the only phase in which a byte may be accepted.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  // UART register map as seen on the APB bus.
  localparam logic [1:0] UART_ADDR_WR = 2'd0;
  localparam logic [1:0] UART_ADDR_RD = 2'd1;

  // Width of the externally visible owner index.
  localparam int OWNER_W = 3;

  // Index width for a vector of n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_uart_tx_arbiter_rr_arbiter.sv
// Round-robin pick: first eligible requester at or after ptr, wrapping modulo N_REQ.
// Latency: purely combinational, grant is valid in the same cycle as the request vector.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter
  import apb_uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] index,
  output logic             found
);

  logic [N_REQ-1:0] eligible;
  logic [IDX_W:0]   pos;

  // Only requesters allowed by the mask (the lock owner, or everyone) compete.
  assign eligible = req & mask;

  // Walk from ptr upward with wrap; the first eligible slot wins and later slots are ignored.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N_REQ)) begin
        pos = pos - (IDX_W+1)'(N_REQ);
      end
      if (!found && eligible[pos[IDX_W-1:0]]) begin
        found                  = 1'b1;
        grant[pos[IDX_W-1:0]]  = 1'b1;
        index                  = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_uart_tx_arbiter.sv
// Arbitrates byte requesters onto one APB write port of a UART TX FIFO, with per-message lock.
// Latency: byte accepted in IDLE, SETUP next cycle, ACCESS after that; minimum 3 cycles per byte.
// Backpressure: M_PREADY low holds ACCESS indefinitely; no req_ready is issued outside IDLE.
module apb_uart_tx_arbiter
  import apb_uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int BUS_WIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [1:0]           M_PADDR,
  output logic                 M_PWRITE,
  output logic                 M_PSELx,
  output logic                 M_PENABLE,
  output logic [BUS_WIDTH-1:0] M_PWDATA,
  input  logic                 M_PREADY,
  output logic                 busy,
  output logic [OWNER_W-1:0]   owner
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_t        state_q;
  apb_state_t        state_d;
  logic [IDX_W-1:0]  ptr_q;
  logic              locked_q;
  logic [IDX_W-1:0]  owner_q;
  logic [7:0]        data_q;
  logic              last_q;
  logic [CNT_W-1:0]  idle_cnt_q;

  logic [N_REQ-1:0]  lock_mask;
  logic [N_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]  arb_index;
  logic              arb_found;
  logic [7:0]        sel_data;
  logic              sel_last;
  logic              take;
  logic              xfer_done;
  logic              owner_stalled;

  // While a message is locked, only its owner may compete; otherwise everyone may.
  assign lock_mask = locked_q ? (N_REQ'(1) << owner_q) : {N_REQ{1'b1}};

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .mask  (lock_mask),
    .grant (arb_grant),
    .index (arb_index),
    .found (arb_found)
  );

  // A byte is taken only in IDLE; reset suppresses the handshake so nothing is half-accepted.
  assign take      = (state_q == ST_IDLE) && arb_found && !reset;
  assign xfer_done = (state_q == ST_ACCESS) && M_PREADY;

  // Owner holds the lock but has nothing to send while the bus is free.
  assign owner_stalled = locked_q && (state_q == ST_IDLE) && !req_valid[owner_q];

  // Steer the winner's byte and last flag through a one-hot mux.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  // APB phase register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next phase plus every bus-facing output; APB signals depend on the phase only.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    M_PSELx   = 1'b0;
    M_PENABLE = 1'b0;
    M_PWRITE  = 1'b0;
    M_PADDR   = 2'b00;
    M_PWDATA  = '0;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          req_ready = arb_grant;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        M_PSELx  = 1'b1;
        M_PWRITE = 1'b1;
        M_PADDR  = UART_ADDR_WR;
        M_PWDATA = BUS_WIDTH'(data_q);
        state_d  = ST_ACCESS;
      end
      ST_ACCESS: begin
        M_PSELx   = 1'b1;
        M_PENABLE = 1'b1;
        M_PWRITE  = 1'b1;
        M_PADDR   = UART_ADDR_WR;
        M_PWDATA  = BUS_WIDTH'(data_q);
        if (M_PREADY) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture the accepted byte; reset discards it so an interrupted transfer is never replayed.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      last_q <= 1'b0;
    end else if (take) begin
      data_q <= sel_data;
      last_q <= sel_last;
    end
  end

  // Fairness pointer, lock ownership and the owner-idle timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      locked_q   <= 1'b0;
      owner_q    <= '0;
      idle_cnt_q <= '0;
    end else begin
      if (take) begin
        owner_q <= arb_index;
        if (arb_index == IDX_W'(N_REQ - 1)) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= arb_index + 1'b1;
        end
        // A multi-byte message claims the port until its last byte has gone out.
        if (!locked_q && !sel_last) begin
          locked_q <= 1'b1;
        end
      end

      // Lock ends when the last byte actually lands in the UART, not when it is accepted.
      if (xfer_done && last_q) begin
        locked_q <= 1'b0;
      end

      // An owner that stays silent too long forfeits the port so others are not starved.
      if (owner_stalled) begin
        if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          locked_q   <= 1'b0;
          idle_cnt_q <= '0;
        end else begin
          idle_cnt_q <= idle_cnt_q + 1'b1;
        end
      end else begin
        idle_cnt_q <= '0;
      end
    end
  end

  assign busy  = locked_q || (state_q != ST_IDLE);
  assign owner = OWNER_W'(owner_q);

endmodule

// File: tb/tb_apb_uart_tx_arbiter.sv
// Directed and randomized checks of apb_uart_tx_arbiter against a cycle-level reference model.
// Latency: model predicts the grant in IDLE and the SETUP/ACCESS phases that follow.
// Backpressure: M_PREADY is held low in directed steps and randomized afterwards.
module tb_apb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [3:0]  last;
  logic        pready;

  logic [3:0]  req_ready;
  logic [1:0]  paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [15:0] pwdata;
  logic        busy;
  logic [2:0]  owner;

  int n_err    = 0;
  int n_checks = 0;
  int cyc      = 0;

  // Reference model state, in protocol terms: phase 0 idle, 1 setup, 2 access.
  int         m_phase = 0;
  int         m_ptr   = 0;
  int         m_owner = 0;
  int         m_idle  = 0;
  bit         m_lock  = 1'b0;
  bit         m_last  = 1'b0;
  logic [7:0] m_byte  = 8'h00;

  logic [3:0]  obs_ready;
  logic        obs_psel;
  logic        obs_pen;
  logic [15:0] obs_pwdata;
  logic        obs_busy;
  logic [2:0]  obs_owner;

  int         grant_idx[$];
  int         grant_cyc[$];
  logic [7:0] apb_log[$];

  apb_uart_tx_arbiter #(
    .N_REQ     (N),
    .BUS_WIDTH (16),
    .TIMEOUT   (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (valid),
    .req_data  (data),
    .req_last  (last),
    .req_ready (req_ready),
    .M_PADDR   (paddr),
    .M_PWRITE  (pwrite),
    .M_PSELx   (psel),
    .M_PENABLE (penable),
    .M_PWDATA  (pwdata),
    .M_PREADY  (pready),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // First valid index at or after p, wrapping modulo N; -1 when nobody asks.
  function automatic int rr_pick(input logic [3:0] v, input int p);
    int r;
    r = -1;
    for (int k = N - 1; k >= 0; k--) begin
      if (v[(p + k) % N]) r = (p + k) % N;
    end
    return r;
  endfunction

  // One clock: sample at the falling edge, compare with the model, advance the model.
  task automatic tick(input bit check_en);
    int         win;
    bit         active;
    logic [3:0] e_ready;
    @(negedge clk);
    obs_ready  = req_ready;
    obs_psel   = psel;
    obs_pen    = penable;
    obs_pwdata = pwdata;
    obs_busy   = busy;
    obs_owner  = owner;
    active     = (m_phase != 0);
    win        = -1;
    if (!reset && m_phase == 0) begin
      if (m_lock) win = valid[m_owner] ? m_owner : -1;
      else        win = rr_pick(valid, m_ptr);
    end
    e_ready = (win >= 0) ? (4'b0001 << win) : 4'b0000;
    if (check_en) begin
      chk("req_ready", req_ready, e_ready);
      chk("M_PSELx",   psel,      active);
      chk("M_PENABLE", penable,   m_phase == 2);
      chk("M_PWRITE",  pwrite,    active);
      chk("M_PADDR",   paddr,     0);
      chk("M_PWDATA",  pwdata,    active ? {8'h00, m_byte} : 16'h0000);
      chk("busy",      busy,      m_lock || active);
      if (m_lock) chk("owner", owner, m_owner);
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        grant_idx.push_back(i);
        grant_cyc.push_back(cyc);
      end
    end
    if (psel && penable && pready) apb_log.push_back(pwdata[7:0]);

    if (reset) begin
      m_phase = 0; m_ptr = 0; m_lock = 1'b0; m_owner = 0;
      m_idle = 0; m_byte = 8'h00; m_last = 1'b0;
    end else if (m_phase == 0) begin
      if (win >= 0) begin
        m_byte  = data[8*win +: 8];
        m_last  = last[win];
        if (!m_lock && !last[win]) m_lock = 1'b1;
        m_owner = win;
        m_ptr   = (win + 1) % N;
        m_idle  = 0;
        m_phase = 1;
      end else if (m_lock) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_lock = 1'b0;
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_idle  = 0;
    end else begin
      m_idle = 0;
      if (pready) begin
        m_phase = 0;
        if (m_last) m_lock = 1'b0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    reset = 1'b1; valid = '0; data = '0; last = '0; pready = 1'b1;
    tick(1'b0);
    tick(1'b1);
    chk("rst_ready",  obs_ready,  0);
    chk("rst_psel",   obs_psel,   0);
    chk("rst_pen",    obs_pen,    0);
    chk("rst_pwdata", obs_pwdata, 0);
    chk("rst_busy",   obs_busy,   0);
    chk("rst_owner",  obs_owner,  0);

    // Single byte.
    reset = 1'b0;
    valid = 4'b0001; data = 32'h0000_0041; last = 4'b0001;
    tick(1'b1);
    chk("s1_grant", obs_ready, 4'b0001);
    valid = '0;
    tick(1'b1);
    chk("s1_setup_psel", obs_psel, 1);
    chk("s1_setup_pen",  obs_pen,  0);
    chk("s1_setup_data", obs_pwdata, 16'h0041);
    tick(1'b1);
    chk("s1_access_pen", obs_pen, 1);
    tick(1'b1);
    chk("s1_done_busy", obs_busy, 0);

    // Contention from reset, every byte a one-byte message.
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    valid = 4'hF; last = 4'hF; data = 32'h1312_1110;
    grant_idx.delete(); grant_cyc.delete();
    base = cyc;
    repeat (13) tick(1'b1);
    chk("s2_ngrants", grant_idx.size(), 5);
    for (int j = 0; j < 5 && j < grant_idx.size(); j++) begin
      chk("s2_order", grant_idx[j], exp_order[j]);
      chk("s2_spacing", grant_cyc[j] - base, 3 * j);
    end
    valid = '0;
    repeat (3) tick(1'b1);

    // Locked two-byte message from requester 2 while requester 0 keeps asking.
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    apb_log.delete(); grant_idx.delete();
    valid = 4'b0100; data = 32'h0041_0000; last = 4'b0000;
    tick(1'b1);
    chk("s3_grantA", obs_ready, 4'b0100);
    valid = 4'b0101; data = 32'h0042_0030; last = 4'b0101;
    repeat (12) begin
      tick(1'b1);
      if (obs_ready[2]) valid[2] = 1'b0;
      if (obs_ready[0]) valid[0] = 1'b0;
    end
    chk("s3_nbytes", apb_log.size(), 3);
    if (apb_log.size() == 3) begin
      chk("s3_byte0", apb_log[0], 8'h41);
      chk("s3_byte1", apb_log[1], 8'h42);
      chk("s3_byte2", apb_log[2], 8'h30);
    end

    // Backpressure: ACCESS held for 10 cycles.
    valid = 4'b0010; data = 32'h0000_5A00; last = 4'b0010; pready = 1'b0;
    tick(1'b1);
    chk("s4_grant", obs_ready, 4'b0010);
    valid = '0;
    tick(1'b1);
    for (int k = 0; k < 10; k++) begin
      tick(1'b1);
      chk("s4_hold_psel", obs_psel, 1);
      chk("s4_hold_pen",  obs_pen,  1);
      chk("s4_hold_data", obs_pwdata, 16'h005A);
      chk("s4_hold_ready", obs_ready, 0);
    end
    pready = 1'b1;
    tick(1'b1);
    chk("s4_last_access", obs_pen, 1);
    tick(1'b1);
    chk("s4_released", obs_psel, 0);

    // Lock timeout: owner 1 goes quiet after a non-final byte.
    valid = 4'b0010; data = 32'h0000_7700; last = 4'b0000;
    tick(1'b1);
    chk("s5_grant1", obs_ready, 4'b0010);
    valid = 4'b1000; data = 32'h3300_7700; last = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      tick(1'b1);
      chk("s5_wait", obs_ready, 0);
    end
    tick(1'b1);
    chk("s5_grant3", obs_ready, 4'b1000);
    valid = '0;
    repeat (3) tick(1'b1);

    // Reset during ACCESS.
    valid = 4'b0100; data = 32'h0099_0000; last = 4'b0000; pready = 1'b0;
    tick(1'b1);
    valid = '0;
    tick(1'b1);
    tick(1'b1);
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    tick(1'b1);
    chk("s6_psel",   obs_psel,   0);
    chk("s6_pen",    obs_pen,    0);
    chk("s6_pwdata", obs_pwdata, 0);
    chk("s6_busy",   obs_busy,   0);
    valid = 4'hF; last = 4'hF; pready = 1'b1;
    tick(1'b1);
    chk("s6_fresh_grant", obs_ready, 4'b0001);
    valid = '0;
    repeat (3) tick(1'b1);

    // Randomized traffic against the model.
    repeat (600) begin
      reset  = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) valid[i] = ($urandom_range(0, 3) == 0);
      data   = $urandom;
      last   = 4'($urandom_range(0, 15));
      pready = ($urandom_range(0, 3) != 0);
      tick(1'b1);
    end
    reset = 1'b0; valid = '0;
    tick(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
